load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: executes one load or store per request over a memory
// request/grant/response handshake. The load result is aligned and sign- or
// zero-extended before it goes back to writeback.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   req_*  / byte_en_i    access request from execute (size code, signed flag,
//   signed_i / addr_i     byte address, store data)
//   wdata_i
//   rsp_*                 one-cycle response: load data and error flag
//   busy_o                stalls the core while a transaction is in flight
//   mem_*                 data-memory request/grant/response interface
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [3:0]  byte_en_i,
  input  logic        signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             we_q, we_d;
  logic [3:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic [1:0]       off_q, off_d;

  logic        req_ready_d, busy_d;
  logic        rsp_valid_d, rsp_err_d;
  logic [31:0] rsp_rdata_d;
  logic        mem_req_d, mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_be_d;

  logic        size_illegal, misaligned, req_bad;
  logic [31:0] rdata_shifted, load_data;

  // Request legality, evaluated on the incoming request at acceptance
  assign size_illegal = (byte_en_i != BE_BYTE) && (byte_en_i != BE_HALF) &&
                        (byte_en_i != BE_WORD);
  assign misaligned   = ((byte_en_i == BE_HALF) && addr_i[0]) ||
                        ((byte_en_i == BE_WORD) && (addr_i[1:0] != 2'b00));
  assign req_bad      = size_illegal || misaligned;

  assign cnt_inc = CNT_W'(cnt_q + 1'b1);

  // Align the returned word to the accessed lane, then extend by size
  assign rdata_shifted = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      BE_BYTE: load_data = {{24{sgn_q & rdata_shifted[7]}},  rdata_shifted[7:0]};
      BE_HALF: load_data = {{16{sgn_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    req_ready_d = req_ready_o;
    busy_d      = busy_o;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_be_d    = mem_be_o;
    mem_wdata_d = mem_wdata_o;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          we_d        = req_we_i;
          size_d      = byte_en_i;
          sgn_d       = signed_i;
          off_d       = addr_i[1:0];
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = '0;
          if (req_bad) begin
            // Rejected without touching memory
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we_i;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_be_d    = 4'(byte_en_i << addr_i[1:0]);
            mem_wdata_d = 32'(wdata_i << {addr_i[1:0], 3'b000});
          end
        end
      end

      S_REQ: begin
        if (mem_gnt_i) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : load_data;
          cnt_d       = '0;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        mem_req_d   = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      off_q       <= '0;
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      req_ready_o <= req_ready_d;
      busy_o      <= busy_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_rdata_o <= rsp_rdata_d;
      rsp_err_o   <= rsp_err_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_be_o    <= mem_be_d;
      mem_wdata_o <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized traffic against a
// byte-addressed reference memory. Responses and memory requests are checked
// by independent monitor processes that pop expected values from queues.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_we, sgn;
  logic [3:0]  byte_en;
  logic [31:0] addr, wdata;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, busy_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .byte_en_i(byte_en), .signed_i(sgn), .addr_i(addr), .wdata_i(wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  typedef struct packed { logic [31:0] rdata; logic err; } rexp_t;
  typedef struct packed { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } mexp_t;

  rexp_t rq[$];
  mexp_t mq[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Controls owned by the main sequence, read by the memory responder
  bit hold_gnt = 0, hold_rv = 0, rand_dly = 0;
  int stray_cnt = 0;
  int mem_req_cycles = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Contents of never-written memory, shared by the responder and the model
  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // ---------------- reference model: byte-addressed little-endian memory
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic int size_bytes(input logic [3:0] be);
    case (be)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  // mode 0: normal, 1: timeout expected, 2: abandoned by reset (no response)
  task automatic issue(input logic we, input logic [3:0] be, input logic s,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int mode, output int lat);
    int nb;
    bit bad, got;
    logic [31:0] v;
    rexp_t re;
    mexp_t me;
    nb  = size_bytes(be);
    bad = (nb == 0) || ((a % nb) != 0);
    lat = 0;
    if (!bad && mode != 1) begin
      me.addr  = a & 32'hFFFF_FFFC;
      me.be    = 4'((32'(1) << nb) - 1) << a[1:0];
      me.we    = we;
      me.wdata = wd << (8 * a[1:0]);
      mq.push_back(me);
    end
    if (mode != 2) begin
      re = '0;
      if (bad || mode == 1) re.err = 1'b1;
      else if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_byte(a + i)) << (8 * i));
        if (s && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        re.rdata = v;
      end
      rq.push_back(re);
    end
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready_o) begin got = 1; break; end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL req_ready_wait: got ready=0 for 100 cycles, expected 1");
      return;
    end
    req_valid = 1; req_we = we; byte_en = be; sgn = s; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 0; req_we = 1'($urandom); byte_en = 4'($urandom);
    sgn = 1'($urandom); addr = $urandom; wdata = $urandom;
    if (mode == 2) return;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (rsp_valid_o) begin lat = k; return; end
    end
    n_checks++;
    $display("FAIL rsp_wait: got no rsp_valid in 60 cycles, expected a response");
  endtask

  // ---------------- response monitor
  initial begin
    rexp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid_o) begin
        if (rq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected none");
        end else begin
          e = rq.pop_front();
          check32("rsp_rdata", rsp_rdata_o, e.rdata);
          check32("rsp_err", 32'(rsp_err_o), 32'(e.err));
        end
      end
    end
  end

  always @(negedge clk) if (mem_req_o) mem_req_cycles++;

  // ---------------- memory responder with word storage
  logic [31:0] wmem [logic [31:0]];
  bit          seen = 0, rv_pend = 0;
  int          g_dly = 0, rv_dly = 0, stray_done = 0;
  logic [31:0] rv_data = '0;

  initial begin
    logic [31:0] w;
    mexp_t e;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 0; mem_rvalid = 0;
      if (!rst_n) begin seen = 0; rv_pend = 0; continue; end
      if (stray_cnt != stray_done) begin
        stray_done++;
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
      end else if (rv_pend && !hold_rv) begin
        if (rv_dly == 0) begin mem_rvalid = 1; mem_rdata = rv_data; rv_pend = 0; end
        else rv_dly--;
      end else if (mem_req_o && !rv_pend && !hold_gnt) begin
        if (!seen) begin seen = 1; g_dly = rand_dly ? $urandom_range(0, 2) : 0; end
        if (g_dly == 0) begin
          mem_gnt = 1; seen = 0;
          if (mq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_mem_req: got mem_req=1 at 0x%08h, expected none", mem_addr_o);
          end else begin
            e = mq.pop_front();
            check32("mem_addr", mem_addr_o, e.addr);
            check32("mem_be", 32'(mem_be_o), 32'(e.be));
            check32("mem_we", 32'(mem_we_o), 32'(e.we));
            if (e.we) check32("mem_wdata", mem_wdata_o, e.wdata);
          end
          w = wmem.exists(mem_addr_o) ? wmem[mem_addr_o] : init_word(mem_addr_o);
          if (mem_we_o) begin
            for (int l = 0; l < 4; l++) if (mem_be_o[l]) w[8*l +: 8] = mem_wdata_o[8*l +: 8];
            wmem[mem_addr_o] = w;
            rv_data = $urandom;
          end else begin
            rv_data = w;
          end
          rv_pend = 1;
          rv_dly  = rand_dly ? $urandom_range(0, 2) : 0;
        end else begin
          g_dly--;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  // ---------------- main sequence
  initial begin
    int lat, c0;
    logic [3:0] be;
    int r;
    req_valid = 0; req_we = 0; byte_en = '0; sgn = 0; addr = '0; wdata = '0;

    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_req_ready", 32'(req_ready_o), 32'd1);
    check32("reset_busy", 32'(busy_o), 32'd0);
    check32("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check32("reset_rsp_rdata", rsp_rdata_o, 32'd0);
    check32("reset_rsp_err", 32'(rsp_err_o), 32'd0);
    check32("reset_mem_req", 32'(mem_req_o), 32'd0);
    check32("reset_mem_we", 32'(mem_we_o), 32'd0);
    check32("reset_mem_addr", mem_addr_o, 32'd0);
    check32("reset_mem_be", 32'(mem_be_o), 32'd0);
    check32("reset_mem_wdata", mem_wdata_o, 32'd0);
    rst_n = 1;

    // Signed byte load from the top lane
    issue(1, 4'b1111, 0, 32'h1000, 32'h80FF_1234, 0, lat);
    issue(0, 4'b0001, 1, 32'h1003, 32'h0, 0, lat);
    check32("lb_latency", 32'(lat), 32'd3);
    // Unsigned half load from the upper half
    issue(1, 4'b1111, 0, 32'h2000, 32'h8001_0000, 0, lat);
    issue(0, 4'b0011, 0, 32'h2002, 32'h0, 0, lat);
    // Byte store into lane 1, then read the word back
    issue(1, 4'b0001, 0, 32'h3001, 32'h0000_00AB, 0, lat);
    check32("sb_latency", 32'(lat), 32'd3);
    issue(0, 4'b1111, 0, 32'h3000, 32'h0, 0, lat);

    // Misaligned word and illegal size: no memory access, error at N+1
    c0 = mem_req_cycles;
    issue(0, 4'b1111, 0, 32'h4002, 32'h0, 0, lat);
    check32("misaligned_latency", 32'(lat), 32'd1);
    issue(0, 4'b0000, 0, 32'h4000, 32'h0, 0, lat);
    check32("illegal_latency", 32'(lat), 32'd1);
    issue(1, 4'b0011, 1, 32'h4001, 32'h1234_5678, 0, lat);
    check32("misaligned_half_latency", 32'(lat), 32'd1);
    check32("err_no_mem_req", 32'(mem_req_cycles - c0), 32'd0);

    // Grant withheld: error after TO cycles in REQ, stray rvalid ignored
    hold_gnt = 1;
    c0 = mem_req_cycles;
    issue(0, 4'b1111, 0, 32'h5000, 32'h0, 1, lat);
    check32("timeout_latency", 32'(lat), 32'(TO + 1));
    check32("timeout_req_cycles", 32'(mem_req_cycles - c0), 32'(TO));
    check32("timeout_mem_req_dropped", 32'(mem_req_o), 32'd0);
    @(negedge clk);
    stray_cnt++;
    repeat (4) @(negedge clk);
    check32("stray_busy", 32'(busy_o), 32'd0);
    check32("stray_req_ready", 32'(req_ready_o), 32'd1);
    hold_gnt = 0;

    // Reset while waiting for read data
    hold_rv = 1;
    issue(0, 4'b1111, 0, 32'h0, 32'h0, 2, lat);
    repeat (2) @(negedge clk);
    check32("wait_busy", 32'(busy_o), 32'd1);
    #2 rst_n = 0;
    #1;
    check32("arst_req_ready", 32'(req_ready_o), 32'd1);
    check32("arst_busy", 32'(busy_o), 32'd0);
    check32("arst_mem_req", 32'(mem_req_o), 32'd0);
    check32("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    hold_rv = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    issue(0, 4'b1111, 0, 32'h0, 32'h0, 0, lat);
    check32("post_reset_lw_latency", 32'(lat), 32'd3);

    // Randomized traffic with random grant/rvalid delays
    rand_dly = 1;
    repeat (100) begin
      r = $urandom_range(0, 9);
      if (r < 3) be = 4'b0001;
      else if (r < 6) be = 4'b0011;
      else if (r < 9) be = 4'b1111;
      else begin
        be = 4'($urandom);
        if (size_bytes(be) != 0) be = 4'b0101;
      end
      issue(1'($urandom), be, 1'($urandom), 32'h100 + $urandom_range(0, 63), $urandom, 0, lat);
    end

    repeat (5) @(negedge clk);
    check32("rsp_queue_empty", 32'(rq.size()), 32'd0);
    check32("mem_queue_empty", 32'(mq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
